// File: rtl/lfsr_prng.sv
// Fibonacci XNOR LFSR word generator with all-ones escape, valid/ready output
// and a free-running chaining pulse (seed_out) for cascaded generators.
module lfsr_prng #(
    parameter int unsigned      WIDTH        = 9,
    parameter logic [WIDTH-1:0] TAPS         = 9'h108,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 9'h001,
    parameter int unsigned      STEP         = 9,
    parameter int unsigned      TICK_PERIOD  = 16,
    parameter int unsigned      TICK_THRESH  = 11
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             lockup,
    output logic             seed_out
);

    localparam int unsigned SW = $clog2(STEP + 1);
    localparam int unsigned TW = $clog2(TICK_PERIOD);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
    localparam logic [TW-1:0] TICK_THR  = TW'(TICK_THRESH);

    typedef enum logic {GEN, VALID} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr, lfsr_d, lfsr_step;
    logic [SW-1:0]    step_cnt, step_d;
    logic [TW-1:0]    tick_cnt, tick_d;
    logic [WIDTH-1:0] data_d;
    logic             valid_d, lockup_d, seed_out_d;
    logic             all_ones, fb;

    always_comb begin
        all_ones  = &lfsr;
        // Forcing fb low on all-ones guarantees the register can never stick there.
        fb        = all_ones ? 1'b0 : ~^(lfsr & TAPS);
        lfsr_step = {lfsr[WIDTH-2:0], fb};

        fsm_d    = fsm_q;
        lfsr_d   = lfsr;
        step_d   = step_cnt;
        valid_d  = out_valid;
        data_d   = out_data;
        lockup_d = 1'b0;

        if (seed_load) begin
            lfsr_d  = seed;
            step_d  = '0;
            valid_d = 1'b0;
            fsm_d   = GEN;
        end else begin
            case (fsm_q)
                GEN: begin
                    if (en) begin
                        lfsr_d   = lfsr_step;
                        lockup_d = all_ones;
                        if (step_cnt == STEP_LAST) begin
                            step_d  = '0;
                            data_d  = lfsr_step;
                            valid_d = 1'b1;
                            fsm_d   = VALID;
                        end else begin
                            step_d = step_cnt + SW'(1);
                        end
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        fsm_d   = GEN;
                    end
                end
                default: fsm_d = GEN;
            endcase
        end

        tick_d     = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
        seed_out_d = (tick_d >= TICK_THR);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fsm_q     <= GEN;
            lfsr      <= SEED_DEFAULT;
            step_cnt  <= '0;
            tick_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            lockup    <= 1'b0;
            seed_out  <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            lfsr      <= lfsr_d;
            step_cnt  <= step_d;
            tick_cnt  <= tick_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            lockup    <= lockup_d;
            seed_out  <= seed_out_d;
        end
    end

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: a STEP=1 instance driven from a vector table
// and a default (STEP=9) instance exercised with hand-written sequences.
module tb_lfsr_prng;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;

    logic       en1 = 0, sl1 = 0, rdy1 = 0;
    logic [8:0] seed1 = '0;
    logic       v1, lk1, so1;
    logic [8:0] d1;

    logic       en9 = 0, sl9 = 0, rdy9 = 0;
    logic [8:0] seed9 = '0;
    logic       v9, lk9, so9;
    logic [8:0] d9;

    int n_chk = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    lfsr_prng #(.STEP(1)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .en(en1), .seed_load(sl1), .seed(seed1),
        .out_ready(rdy1), .out_valid(v1), .out_data(d1), .lockup(lk1), .seed_out(so1)
    );

    lfsr_prng u9 (
        .Clk(Clk), .Reset_n(Reset_n), .en(en9), .seed_load(sl9), .seed(seed9),
        .out_ready(rdy9), .out_valid(v9), .out_data(d9), .lockup(lk9), .seed_out(so9)
    );

    typedef struct {
        logic       sl;
        logic [8:0] seed;
        logic       en;
        logic       rdy;
        logic       ev;
        logic [8:0] ed;
        logic       elk;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        cyc();
        chk("rst_v1", v1, 0);   chk("rst_d1", d1, 0);
        chk("rst_lk1", lk1, 0); chk("rst_so1", so1, 0);
        chk("rst_v9", v9, 0);   chk("rst_d9", d9, 0);
        chk("rst_lk9", lk9, 0); chk("rst_so9", so9, 0);
        Reset_n = 1'b1;
    endtask

    task automatic wait_v9(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!v9 && n < budget);
        if (!v9) chk("wait_v9_timeout", 0, 1);
    endtask

    initial begin
        int n;

        tbl[0]  = '{0, 9'h000, 1, 1, 1, 9'h003, 0};
        tbl[1]  = '{0, 9'h000, 1, 1, 0, 9'h003, 0};
        tbl[2]  = '{0, 9'h000, 1, 1, 1, 9'h007, 0};
        tbl[3]  = '{0, 9'h000, 1, 1, 0, 9'h007, 0};
        tbl[4]  = '{0, 9'h000, 1, 1, 1, 9'h00F, 0};
        tbl[5]  = '{0, 9'h000, 1, 1, 0, 9'h00F, 0};
        tbl[6]  = '{0, 9'h000, 1, 1, 1, 9'h01E, 0};
        tbl[7]  = '{0, 9'h000, 1, 1, 0, 9'h01E, 0};
        tbl[8]  = '{1, 9'h1FF, 1, 1, 0, 9'h01E, 0};
        tbl[9]  = '{0, 9'h000, 1, 1, 1, 9'h1FE, 1};
        tbl[10] = '{0, 9'h000, 1, 1, 0, 9'h1FE, 0};
        tbl[11] = '{0, 9'h000, 1, 1, 1, 9'h1FD, 0};
        tbl[12] = '{0, 9'h000, 1, 1, 0, 9'h1FD, 0};
        tbl[13] = '{0, 9'h000, 1, 1, 1, 9'h1FB, 0};
        tbl[14] = '{0, 9'h000, 1, 1, 0, 9'h1FB, 0};
        tbl[15] = '{0, 9'h000, 0, 1, 0, 9'h1FB, 0};
        tbl[16] = '{0, 9'h000, 1, 1, 1, 9'h1F7, 0};
        tbl[17] = '{0, 9'h000, 0, 0, 1, 9'h1F7, 0};
        tbl[18] = '{0, 9'h000, 0, 1, 0, 9'h1F7, 0};

        // Chaining pulse: low while tick count 0..10, high 11..15, period 16.
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            cyc();
            chk("seed_out9", so9, ((k % 16) >= 11) ? 1 : 0);
            chk("seed_out1", so1, ((k % 16) >= 11) ? 1 : 0);
        end
        chk("idle_v9", v9, 0);

        // STEP=1 table: default sequence, all-ones escape, en/ready holds.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            sl1 = tbl[i].sl; seed1 = tbl[i].seed; en1 = tbl[i].en; rdy1 = tbl[i].rdy;
            cyc();
            chk($sformatf("tbl%0d_valid", i), v1, tbl[i].ev);
            chk($sformatf("tbl%0d_data", i), d1, tbl[i].ed);
            chk($sformatf("tbl%0d_lockup", i), lk1, tbl[i].elk);
        end
        en1 = 1; rdy1 = 1; sl1 = 0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            chk("no_relock_data", (d1 == 9'h1FF) ? 1 : 0, 0);
            chk("no_relock_pulse", lk1, 0);
        end
        en1 = 0; rdy1 = 0;

        // STEP=9 back-pressure: word held, then the next word is 18 shifts in.
        do_reset();
        en9 = 1; rdy9 = 0;
        wait_v9(30, n);
        chk("bp_first_latency", n, 9);
        chk("bp_first_word", d9, 9'h1C2);
        for (int k = 0; k < 25; k++) begin
            cyc();
            chk("bp_hold_valid", v9, 1);
            chk("bp_hold_data", d9, 9'h1C2);
        end
        rdy9 = 1;
        cyc();
        chk("bp_release_valid", v9, 0);
        wait_v9(30, n);
        chk("bp_second_latency", n, 9);
        chk("bp_second_word", d9, 9'h07A);
        cyc();
        chk("bp_second_ack", v9, 0);

        // en toggling halves the rate but leaves the word unchanged.
        rdy9 = 0; en9 = 0;
        do_reset();
        n = 0;
        do begin
            n++;
            en9 = ((n % 2) == 0);
            cyc();
        end while (!v9 && n < 40);
        chk("toggle_latency", n, 18);
        chk("toggle_word", d9, 9'h1C2);

        // seed_load while VALID drops the pending word.
        sl9 = 1; seed9 = 9'h0A5; en9 = 1; rdy9 = 0;
        cyc();
        chk("reload_valid_drop", v9, 0);
        sl9 = 0;
        wait_v9(30, n);
        chk("reload_latency", n, 9);
        chk("reload_word", d9, 9'h1E4);

        // Reset mid-word, with seed_load also asserted: reset must win.
        do_reset();
        en9 = 1; rdy9 = 0;
        repeat (4) cyc();
        sl9 = 1; seed9 = 9'h0A5;
        do_reset();
        sl9 = 0;
        wait_v9(30, n);
        chk("rst_midword_latency", n, 9);
        chk("rst_midword_word", d9, 9'h1C2);

        // Reset mid-VALID.
        repeat (3) cyc();
        chk("pre_rst_valid", v9, 1);
        sl9 = 1;
        do_reset();
        sl9 = 0;
        wait_v9(30, n);
        chk("rst_midvalid_latency", n, 9);
        chk("rst_midvalid_word", d9, 9'h1C2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
